// File: rtl/idex_pkg.sv
// Shared types for the ID->EX elastic stage.
//   idex_payload_t : instruction bundle carried from decode to execute
//   skid_state_t   : occupancy state of the 2-entry skid buffer
package idex_pkg;

  localparam int unsigned PC_WIDTH      = 64;
  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned CONTROL_WIDTH = 16;

  typedef struct packed {
    logic [PC_WIDTH-1:0]      pc;
    logic [DATA_WIDTH-1:0]    val_a;
    logic [DATA_WIDTH-1:0]    val_b;
    logic [DATA_WIDTH-1:0]    imm;
    logic [CONTROL_WIDTH-1:0] control;
  } idex_payload_t;

  localparam int unsigned PAYLOAD_WIDTH = $bits(idex_payload_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_t;

  // Number of entries held in a given state.
  function automatic logic [1:0] occupancy_of(skid_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_FULL: occ = 2'd1;
      ST_SKID: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/idex_elastic_stage_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready handshake and flush.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : drop all held entries and the concurrent input
//   in_valid/ready : upstream handshake (ready is registered)
//   in_data        : upstream payload
//   out_valid/ready: downstream handshake (valid is registered)
//   out_data       : head entry (main register)
//   occupancy      : entries held, 0..2
module skid_buf
  import idex_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       occupancy_q, occupancy_d;
  logic             in_fire;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occupancy_q;
  assign in_fire   = in_valid & in_ready_q;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
    end
  end

  // Next-state and next-register logic; flush overrides the handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end
      end
      ST_FULL: begin
        // out_valid is 1 here, so out_fire reduces to out_ready.
        if (in_fire && out_ready) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_SKID;
          skid_d  = in_data;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          state_d = ST_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end

    in_ready_d  = (state_d != ST_SKID);
    out_valid_d = (state_d != ST_EMPTY);
    occupancy_d = occupancy_of(state_d);
  end

endmodule

// File: rtl/idex_elastic_stage.sv
// Elastic ID->EX pipeline stage between decode/regfile read and the ALU.
//   clk, reset, flush           : clock, sync active-high reset, wrong-path kill
//   in_valid/in_ready           : decode-side handshake (in_ready registered)
//   pc_in, val_a_in, val_b_in,
//   imm_in, control_in          : incoming instruction payload
//   out_valid/out_ready         : execute-side handshake
//   pc_out, val_a_out, val_b_out,
//   imm_out, control_out        : head entry payload
//   occupancy                   : entries held, 0..2
module idex_elastic_stage
  import idex_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_WIDTH-1:0]      pc_in,
  input  logic [DATA_WIDTH-1:0]    val_a_in,
  input  logic [DATA_WIDTH-1:0]    val_b_in,
  input  logic [DATA_WIDTH-1:0]    imm_in,
  input  logic [CONTROL_WIDTH-1:0] control_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_WIDTH-1:0]      pc_out,
  output logic [DATA_WIDTH-1:0]    val_a_out,
  output logic [DATA_WIDTH-1:0]    val_b_out,
  output logic [DATA_WIDTH-1:0]    imm_out,
  output logic [CONTROL_WIDTH-1:0] control_out,
  output logic [1:0]               occupancy
);

  idex_payload_t in_pl;
  idex_payload_t out_pl;

  // Pack decode-side fields into one bus.
  assign in_pl.pc      = pc_in;
  assign in_pl.val_a   = val_a_in;
  assign in_pl.val_b   = val_b_in;
  assign in_pl.imm     = imm_in;
  assign in_pl.control = control_in;

  skid_buf #(
    .WIDTH(PAYLOAD_WIDTH)
  ) u_skid_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pl),
    .occupancy(occupancy)
  );

  // Unpack the head entry for execute.
  assign pc_out      = out_pl.pc;
  assign val_a_out   = out_pl.val_a;
  assign val_b_out   = out_pl.val_b;
  assign imm_out     = out_pl.imm;
  assign control_out = out_pl.control;

endmodule

// File: tb/tb_idex_elastic_stage.sv
// Scoreboard bench for idex_elastic_stage: inputs driven and outputs sampled
// at the falling edge; accepted instructions are queued and compared in order
// as execute consumes them.
module tb_idex_elastic_stage;
  import idex_pkg::*;

  localparam int unsigned PW = PAYLOAD_WIDTH;

  logic                     clk;
  logic                     reset;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [PC_WIDTH-1:0]      pc_in;
  logic [DATA_WIDTH-1:0]    val_a_in;
  logic [DATA_WIDTH-1:0]    val_b_in;
  logic [DATA_WIDTH-1:0]    imm_in;
  logic [CONTROL_WIDTH-1:0] control_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [PC_WIDTH-1:0]      pc_out;
  logic [DATA_WIDTH-1:0]    val_a_out;
  logic [DATA_WIDTH-1:0]    val_b_out;
  logic [DATA_WIDTH-1:0]    imm_out;
  logic [CONTROL_WIDTH-1:0] control_out;
  logic [1:0]               occupancy;

  idex_elastic_stage dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc_in      (pc_in),
    .val_a_in   (val_a_in),
    .val_b_in   (val_b_in),
    .imm_in     (imm_in),
    .control_in (control_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc_out     (pc_out),
    .val_a_out  (val_a_out),
    .val_b_out  (val_b_out),
    .imm_out    (imm_out),
    .control_out(control_out),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   nvec;
  int unsigned   nerr;
  idex_payload_t sb_q[$];
  logic          hold_pending;
  idex_payload_t hold_val;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic idex_payload_t make_payload(input logic [PC_WIDTH-1:0] pc);
    idex_payload_t p;
    p.pc      = pc;
    p.val_a   = pc ^ 64'hA5A5_0000_FFFF_1234;
    p.val_b   = ~pc;
    p.imm     = {pc[31:0], pc[63:32]};
    p.control = pc[15:0] ^ 16'h5A3C;
    return p;
  endfunction

  function automatic idex_payload_t cur_out();
    idex_payload_t p;
    p.pc      = pc_out;
    p.val_a   = val_a_out;
    p.val_b   = val_b_out;
    p.imm     = imm_out;
    p.control = control_out;
    return p;
  endfunction

  task automatic drive(input logic v, input logic [PC_WIDTH-1:0] pc, input logic ordy,
                       input logic fl, input logic rst);
    idex_payload_t p;
    p          = make_payload(pc);
    in_valid   = v;
    pc_in      = p.pc;
    val_a_in   = p.val_a;
    val_b_in   = p.val_b;
    imm_in     = p.imm;
    control_in = p.control;
    out_ready  = ordy;
    flush      = fl;
    reset      = rst;
  endtask

  // Called at a falling edge with inputs already applied: check state against
  // the scoreboard, predict this rising edge's transfers, then advance.
  task automatic step();
    logic          inf;
    logic          outf;
    idex_payload_t exp_p;
    check("occupancy", PW'(occupancy), PW'(sb_q.size()));
    check("out_valid", PW'(out_valid), PW'(sb_q.size() != 0));
    check("in_ready", PW'(in_ready), PW'(sb_q.size() != 2));
    if (hold_pending) check("hold_stable", cur_out(), hold_val);
    hold_pending = out_valid & ~out_ready & ~flush & ~reset;
    hold_val     = cur_out();

    inf  = in_valid & in_ready & ~flush & ~reset;
    outf = out_valid & out_ready & ~flush & ~reset;
    if (outf) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", PW'(1), PW'(0));
      end else begin
        exp_p = sb_q.pop_front();
        check("payload", cur_out(), exp_p);
      end
    end
    if (reset || flush) sb_q.delete();
    else if (inf) sb_q.push_back(make_payload(pc_in));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nvec         = 0;
    nerr         = 0;
    hold_pending = 1'b0;
    hold_val     = '0;

    // Reset held two cycles while decode presents an instruction.
    drive(1'b1, 64'h0000_0000_0000_0BAD, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", PW'(out_valid), PW'(0));
    check("rst_in_ready", PW'(in_ready), PW'(1));
    check("rst_occupancy", PW'(occupancy), PW'(0));
    check("rst_payload", cur_out(), PW'(0));

    // Streaming: eight back-to-back instructions with execute always ready.
    for (int k = 0; k < 8; k++) begin
      check("stream_in_ready", PW'(in_ready), PW'(1));
      drive(1'b1, 64'h1000 + 64'(4 * k), 1'b1, 1'b0, 1'b0);
      step();
      check("stream_pc", PW'(pc_out), PW'(64'h1000 + 64'(4 * k)));
      check("stream_latency", PW'(out_valid), PW'(1));
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    check("stream_drained", PW'(out_valid), PW'(0));

    // Backpressure into the skid entry, then drain in order.
    drive(1'b1, 64'h2000, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h2004, 1'b0, 1'b0, 1'b0);
    step();
    check("bp_occupancy", PW'(occupancy), PW'(2));
    check("bp_in_ready", PW'(in_ready), PW'(0));
    check("bp_head_pc", PW'(pc_out), PW'(64'h2000));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    check("bp_second_pc", PW'(pc_out), PW'(64'h2004));
    check("bp_ready_back", PW'(in_ready), PW'(1));
    step();
    check("bp_empty", PW'(occupancy), PW'(0));

    // Flush while full with a concurrent valid input.
    drive(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h3004, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h3008, 1'b0, 1'b1, 1'b0);
    step();
    check("fl_out_valid", PW'(out_valid), PW'(0));
    check("fl_occupancy", PW'(occupancy), PW'(0));
    check("fl_in_ready", PW'(in_ready), PW'(1));
    check("fl_payload", cur_out(), PW'(0));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    check("fl_no_ghost", PW'(out_valid), PW'(0));

    // Reset and flush together while full; then a lone instruction.
    drive(1'b1, 64'h3100, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h3104, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h3108, 1'b0, 1'b1, 1'b1);
    step();
    check("rf_out_valid", PW'(out_valid), PW'(0));
    check("rf_in_ready", PW'(in_ready), PW'(1));
    check("rf_occupancy", PW'(occupancy), PW'(0));
    check("rf_payload", cur_out(), PW'(0));
    drive(1'b1, 64'h4000, 1'b0, 1'b0, 1'b0);
    step();
    check("rf_alone_occ", PW'(occupancy), PW'(1));
    check("rf_alone_pc", PW'(pc_out), PW'(64'h4000));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    check("rf_alone_gone", PW'(out_valid), PW'(0));

    // Random valid/ready with occasional flush.
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    check("final_empty", PW'(sb_q.size()), PW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
